// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - register-driven LED sequencer: static, blink, PWM-dim and walking modes
module led_pattern_ctrl #(
    parameter int NLED         = 8,
    parameter int PWM_BITS     = 8,
    parameter int TICKCNT_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ctrl_reg,
    input  logic [31:0]     period_reg,
    output logic [NLED-1:0] led,
    output logic [31:0]     status
);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;
    localparam logic [1:0] MODE_WALK   = 2'b11;

    logic [NLED-1:0]         pattern;
    logic [1:0]              mode;
    logic                    walk_right;
    logic [PWM_BITS-1:0]     duty;
    logic                    unused_ctrl_bits;

    assign pattern          = ctrl_reg[NLED-1:0];
    assign mode             = ctrl_reg[9:8];
    assign walk_right       = ctrl_reg[10];
    assign duty             = ctrl_reg[16 +: PWM_BITS];
    assign unused_ctrl_bits = ^{ctrl_reg[31:24], ctrl_reg[15:11]};

    logic [31:0]             presc_q, presc_d;
    logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [TICKCNT_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic                    phase_q, phase_d;
    logic [NLED-1:0]         walk_q, walk_d;
    logic [1:0]              mode_q, mode_d;
    logic [NLED-1:0]         pat_q, pat_d;
    logic [NLED-1:0]         led_q, led_d;
    logic [31:0]             status_q, status_d;

    logic                    tick;
    logic                    mode_chg;
    logic                    pat_chg;

    // Prescaler tick and change detection against the stored copies
    always_comb begin
        tick     = (presc_q >= period_reg);
        mode_chg = (mode != mode_q);
        pat_chg  = (pattern != pat_q);
    end

    // Counters, blink phase and walk register; a mode change overrides a coincident tick
    always_comb begin
        presc_d    = presc_q;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        walk_d     = walk_q;
        mode_d     = mode;
        pat_d      = pattern;

        if (mode_chg) begin
            presc_d    = '0;
            tick_cnt_d = '0;
            phase_d    = 1'b0;
            walk_d     = pattern;
        end else begin
            presc_d = tick ? '0 : presc_q + 32'd1;
            if (tick) begin
                tick_cnt_d = tick_cnt_q + 1'b1;
                phase_d    = ~phase_q;
            end
            if (mode == MODE_WALK) begin
                if (pat_chg) begin
                    walk_d = pattern;
                end else if (tick) begin
                    walk_d = walk_right ? {walk_q[0], walk_q[NLED-1:1]}
                                        : {walk_q[NLED-2:0], walk_q[NLED-1]};
                end
            end
        end
    end

    // LED drive and status word, built from the state being loaded this edge
    always_comb begin
        led_d = '0;
        case (mode)
            MODE_STATIC: led_d = pattern;
            MODE_BLINK:  led_d = phase_d ? '0 : pattern;
            MODE_PWM:    led_d = (pwm_cnt_q < duty) ? pattern : '0;
            MODE_WALK:   led_d = walk_d;
            default:     led_d = '0;
        endcase
        status_d                      = '0;
        status_d[NLED-1:0]            = led_d;
        status_d[8 +: TICKCNT_BITS]   = tick_cnt_d;
        status_d[17:16]               = mode_d;
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
            walk_q     <= '0;
            mode_q     <= MODE_STATIC;
            pat_q      <= '0;
            led_q      <= '0;
            status_q   <= '0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            walk_q     <= walk_d;
            mode_q     <= mode_d;
            pat_q      <= pat_d;
            led_q      <= led_d;
            status_q   <= status_d;
        end
    end

    assign led    = led_q;
    assign status = status_q;

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Register-driven LED sequencer.
- Sits directly downstream of the PCIe/AXI register bank, in the axi_clk domain.
- Consumes the control word (slv_reg7) and period word (slv_reg8). Drives the 8 board LEDs. Returns a status word that is wired to slv_read7.
- Replaces the plain static LED assignment with static, blink, PWM-dim and walking modes.

Parameters:
- NLED, 8, number of LED outputs; pattern and status LED fields are NLED wide.
- PWM_BITS, 8, width of the free-running PWM counter and of the duty field.
- TICKCNT_BITS, 8, width of the tick counter reported in status.

Ports:
- clk  input  1  axi_clk; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; release synchronous to clk.
- ctrl_reg  input  32  control word, synchronous to clk.
  - [NLED-1:0] pattern.
  - [9:8] mode: 00 static, 01 blink, 10 pwm, 11 walk.
  - [10] walk direction: 0 left, 1 right.
  - [23:16] pwm duty.
  - other bits ignored.
- period_reg  input  32  tick divider; one tick every period_reg+1 clk cycles.
- led  output  NLED  registered LED drive.
- status  output  32  status word.
  - [NLED-1:0] current led.
  - [15:8] tick count (wraps).
  - [17:16] active mode.
  - [31:18] zero.

Behaviour:
- Reset (async, rst_n=0):
  - led=0, status=0.
  - Prescale counter=0, PWM counter=0, tick count=0, blink phase=0.
  - Walk register=0, stored mode=00, stored pattern=0.
- Inputs are already in the clk domain; no synchronisers.
- Prescaler:
  - 32-bit counter; when counter==period_reg, emit a 1-cycle tick and clear the counter; otherwise increment.
  - period_reg=0 gives a tick every cycle.
  - If period_reg is lowered below the current count, the counter rolls through 2^32 wrap to reach it. Required and tested only at the boundary case below.
  - Rule: compare uses ">=" instead of "==". Counter clears on the cycle after period_reg drops to or below it; no 2^32 wait.
- Tick count: increments on each tick, modulo 2^TICKCNT_BITS.
- Mode/pattern change detect:
  - Stored copies of mode and pattern are registered each cycle.
  - If mode differs from the stored copy: clear prescaler, blink phase and tick count, and load walk register from pattern. This happens on the cycle after the change.
  - Pattern change alone in walk mode reloads the walk register the next cycle. In other modes it is only tracked.
- Modes (led is registered, updated every cycle):
  - Static: led = pattern; 1-cycle latency from ctrl_reg to led.
  - Blink: blink phase toggles on each tick; led = phase ? 0 : pattern. Entry shows pattern first.
  - PWM: PWM counter free-runs, wrapping at 2^PWM_BITS. led = (cnt < duty) ? pattern : 0.
    - duty=0: always off.
    - duty=255: on 255 of 256 cycles.
    - The PWM counter does not reset on mode change.
  - Walk: on each tick, rotate the walk register by 1 (dir 0: toward MSB, MSB into bit0; dir 1: reverse). led = walk register.
    - Pattern 0: stays 0.
    - Direction change takes effect at the next tick without a reload.
- Simultaneous tick and mode change: the mode change wins. Counters clear; no rotate or toggle that cycle.
- status is registered: same cycle as led, mode field equals the stored mode.
- Size: combinational depth of at most a 32-bit compare plus increment per cycle at 250 MHz.

Test Plan:
- Reset then idle: rst_n low mid-operation in walk mode → led=0 and status=0 immediately, without waiting for a clk edge. After release with ctrl_reg=0x0000_00A5, mode 00 → led=0xA5 after 1 clk.
- Blink: ctrl=0x0000_013C, period=3 → led alternates 0x3C / 0x00, each phase 4 cycles. status[15:8] increments every 4 cycles.
- PWM: ctrl=0x0040_02FF, period=0 → over 256 cycles led=0xFF exactly 64 cycles, 0x00 for 192. Duty 0x00 → 0 cycles on; duty 0xFF → 255 on.
- Walk left: ctrl=0x0000_0301, period=1 → led 01,02,04,…,80,01 every 2 cycles. Set bit10 → sequence reverses at the next tick. Pattern 0x81 reload → 81,03,06,… .
- Boundary: with the prescaler at 1000, change period from 5000 to 10 → tick within 2 cycles. A mode change on the same cycle as a tick → tick count 0 and no rotate.
- Pattern-only change in static/blink: ctrl pattern 0x11→0x22 with mode 01 held → phase and tick count are not cleared, and led shows 0x22 at the next on-phase.
